// File: rtl/phase_sequencer.sv
// Tick-paced phase sequencer feeding a CORDIC stage with start vector and angle.
// Optional dither on the captured angle: define PHASE_SEQUENCER_DITHER_EN.
module phase_sequencer #(
    parameter int               ACC_WIDTH = 16,
    parameter logic signed [7:0] X_INIT   = 8'sd78
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  enable_i,
    input  logic [ACC_WIDTH-1:0]  freq_word_i,
    input  logic signed [7:0]     phase_offset_i,
    input  logic [7:0]            div_i,
    input  logic                  cordic_done_i,
    output logic signed [7:0]     X_o,
    output logic signed [7:0]     Y_o,
    output logic signed [7:0]     Z_o,
    output logic                  strb_data_valid_o,
    output logic                  busy_o,
    output logic                  overrun_o
);
    typedef enum logic [1:0] {IDLE, COUNT, ISSUE, WAIT} state_t;

    state_t               state;
    logic [7:0]           cnt;
    logic [ACC_WIDTH-1:0] acc;
    logic                 tick;
    logic [7:0]           z_next;

    assign tick = (state != IDLE) && (cnt == div_i);
    assign X_o  = X_INIT;
    assign Y_o  = '0;

`ifdef PHASE_SEQUENCER_DITHER_EN
    logic [7:0] lfsr;

    // Advances on every accepted or dropped tick so the dither stays tick-locked.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            lfsr <= 8'hA5;
        else if (enable_i && tick)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign z_next = acc[ACC_WIDTH-1 -: 8] + $unsigned(phase_offset_i) + {7'd0, lfsr[0]};
`else
    assign z_next = acc[ACC_WIDTH-1 -: 8] + $unsigned(phase_offset_i);
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state             <= IDLE;
            cnt               <= '0;
            acc               <= '0;
            Z_o               <= '0;
            strb_data_valid_o <= 1'b0;
            busy_o            <= 1'b0;
            overrun_o         <= 1'b0;
        end else if (!enable_i) begin
            // Dropping enable abandons any in-flight request immediately.
            state             <= IDLE;
            cnt               <= '0;
            acc               <= '0;
            strb_data_valid_o <= 1'b0;
            busy_o            <= 1'b0;
            overrun_o         <= 1'b0;
        end else begin
            strb_data_valid_o <= 1'b0;
            if (state == IDLE) begin
                cnt       <= '0;
                acc       <= '0;
                overrun_o <= 1'b0;
                busy_o    <= 1'b0;
                state     <= COUNT;
            end else begin
                cnt <= tick ? 8'd0 : cnt + 8'd1;
                if (tick)
                    acc <= acc + freq_word_i;
                case (state)
                    COUNT: if (tick) begin
                        Z_o               <= z_next;
                        strb_data_valid_o <= 1'b1;
                        busy_o            <= 1'b1;
                        state             <= ISSUE;
                    end
                    ISSUE: begin
                        if (tick)
                            overrun_o <= 1'b1;
                        state <= WAIT;
                    end
                    WAIT: begin
                        // A tick landing with done is still a dropped sample.
                        if (tick)
                            overrun_o <= 1'b1;
                        if (cordic_done_i) begin
                            busy_o <= 1'b0;
                            state  <= COUNT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_phase_sequencer.sv
// Vector table plus scoreboard of expected angles; hand sequences for disable and async reset.
module tb_phase_sequencer;
    logic        clk = 1'b0, rstn = 1'b0, en = 1'b0, done = 1'b0;
    logic [15:0] fw = '0;
    logic [7:0]  off = '0, dv = '0;
    logic [7:0]  xo, yo, zo;
    logic        strb, busy, ovr;
    int          checks = 0, errors = 0;

    phase_sequencer dut (
        .clk_i(clk), .rstn_i(rstn), .enable_i(en), .freq_word_i(fw),
        .phase_offset_i(off), .div_i(dv), .cordic_done_i(done),
        .X_o(xo), .Y_o(yo), .Z_o(zo),
        .strb_data_valid_o(strb), .busy_o(busy), .overrun_o(ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  div;
        logic [15:0] fw;
        logic [7:0]  off;
        int          d;       // done edge, clocks after the strobing tick
        int          n;       // strobes to collect
        int          period;  // expected strobe spacing in clocks
        logic        ovr;     // expected overrun at end
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic dith(input int k);
`ifdef PHASE_SEQUENCER_DITHER_EN
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 0; i < k; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        return s[0];
`else
        return 1'b0 & k[0];
`endif
    endfunction

    task automatic do_reset();
        rstn = 1'b0; en = 1'b0; done = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0]  zq[$];
        logic [31:0] prod;
        logic [7:0]  ze;
        int cd, seen, tps, p, budget;
        p = int'(v.div) + 1;
        tps = v.period / p;
        cd = 0; seen = 0;
        budget = p + 1 + v.n * v.period + 20;
        do_reset();
        dv = v.div; fw = v.fw; off = v.off;
        for (int j = 0; j < v.n; j++) begin
            prod = 32'(j * tps) * 32'(v.fw);
            ze = prod[15:8] + v.off + {7'd0, dith(j * tps)};
            zq.push_back(ze);
        end
        en = 1'b1;
        for (int k = 1; k <= budget && seen < v.n; k++) begin
            @(negedge clk);
            done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) done = 1'b1;
            end
            if (strb) begin
                chk("strobe_time", k, p + 1 + seen * v.period);
                chk("busy_on_strobe", busy, 1);
                chk("z", zo, zq.pop_front());
                seen++;
                cd = v.d - 1;
                if (cd == 0) done = 1'b1;
            end
        end
        chk("strobe_count", seen, v.n);
        chk("overrun", ovr, v.ovr);
        @(negedge clk);
        done = 1'b0;
        chk("strobe_one_cycle", strb, 0);
    endtask

    task automatic wait_strobe(output int k);
        k = 0;
        for (int i = 1; i <= 300 && k == 0; i++) begin
            @(negedge clk);
            if (strb) k = i;
        end
        chk("strobe_seen", k != 0, 1);
    endtask

    initial begin
        vec_t vt[6];
        int k, cnt;
        vt[0] = '{8'd15, 16'h1000, 8'h00, 9, 5, 16, 1'b0};
        vt[1] = '{8'd15, 16'h4000, 8'h40, 9, 5, 16, 1'b0};
        vt[2] = '{8'd3,  16'h1000, 8'h00, 9, 4, 12, 1'b1};
        vt[3] = '{8'd7,  16'h0123, 8'hFD, 8, 4, 16, 1'b1};
        vt[4] = '{8'd2,  16'h8000, 8'h00, 2, 3, 3,  1'b0};
        vt[5] = '{8'd0,  16'h0100, 8'h10, 2, 3, 3,  1'b1};

        #3;
        chk("rst_x", xo, 8'h4E);
        chk("rst_y", yo, 0);
        chk("rst_z", zo, 0);
        chk("rst_strb", strb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", ovr, 0);

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Overrun while stuck in WAIT, then disable clears everything
        do_reset();
        dv = 8'd3; fw = 16'h1000; off = 8'h05; en = 1'b1;
        wait_strobe(k);
        repeat (5) @(negedge clk);
        chk("wait_busy", busy, 1);
        chk("wait_ovr", ovr, 1);
        en = 1'b0;
        @(negedge clk);
        chk("dis_busy", busy, 0);
        chk("dis_ovr", ovr, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (strb) cnt++;
        end
        chk("dis_no_strobe", cnt, 0);
        dv = 8'd15; en = 1'b1;
        wait_strobe(k);
        chk("reen_latency", k, 17);
        chk("reen_z", zo, 8'h05 + {7'd0, dith(2)});

        // Asynchronous reset while strobe is high
        do_reset();
        dv = 8'd3; fw = 16'h1000; off = 8'h22; en = 1'b1;
        wait_strobe(k);
        chk("pre_rst_z", zo, 8'h22 + {7'd0, dith(0)});
        #2 rstn = 1'b0;
        #1;
        chk("arst_strb", strb, 0);
        chk("arst_busy", busy, 0);
        chk("arst_z", zo, 0);
        chk("arst_ovr", ovr, 0);
        chk("arst_x", xo, 8'h4E);
        @(negedge clk);
        rstn = 1'b1;
        wait_strobe(k);
        chk("post_rst_latency", k, 5);
        chk("post_rst_z", zo, 8'h22 + {7'd0, dith(0)});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 16: phase accumulator width, >= 9.
REQ-002 SHALL have parameter X_INIT, default 8'sd78: gain-compensated start vector, 1/K of 0.6073 in Q0.7.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port enable_i, input, 1: run request.
REQ-006 SHALL have port freq_word_i, input, ACC_WIDTH: phase increment per sample tick.
REQ-007 SHALL have port phase_offset_i, input, 8 signed: offset added to the angle.
REQ-008 SHALL have port div_i, input, 8: sample period in clocks, minus 1.
REQ-009 SHALL have port cordic_done_i, input, 1: completion strobe from the CORDIC stage.
REQ-010 SHALL have ports X_o, Y_o, Z_o, output, 8 signed each: CORDIC start vector and angle.
REQ-011 SHALL have port strb_data_valid_o, input-side strobe to CORDIC, output, 1: X_o/Y_o/Z_o valid this cycle.
REQ-012 SHALL have ports busy_o, output, 1 (state ISSUE or WAIT), and overrun_o, output, 1 (sticky dropped-tick flag).

Function
REQ-013 SHALL implement FSM states IDLE, COUNT, ISSUE, WAIT.
REQ-014 SHALL, in IDLE, hold tick counter and accumulator at 0, clear overrun_o, and go to COUNT when enable_i=1.
REQ-015 SHALL, in COUNT/ISSUE/WAIT, increment the 8-bit tick counter each clock; when counter==div_i, reset it to 0 and assert one-cycle tick.
REQ-016 SHALL, on every tick edge, capture Z_o = acc[ACC_WIDTH-1 -: 8] + phase_offset_i (mod 256) and then set acc <= acc + freq_word_i (mod 2^ACC_WIDTH).
REQ-017 SHALL transition COUNT -> ISSUE on tick; ISSUE asserts strb_data_valid_o for exactly one cycle with the captured Z_o.
REQ-018 SHALL transition ISSUE -> WAIT unconditionally, and WAIT -> COUNT on cordic_done_i=1.
REQ-019 SHALL, on a tick in ISSUE or WAIT, leave state unchanged, set overrun_o=1, still advance acc, and leave Z_o unchanged.
REQ-020 SHALL, on cordic_done_i coinciding with a tick in WAIT, treat it as overrun and go to COUNT.
REQ-021 SHALL ignore cordic_done_i outside WAIT.
REQ-022 SHALL hold X_o=X_INIT and Y_o=0 constantly.
REQ-023 SHALL make angle 8'h40 mean +pi/2; the natural 8-bit wrap maps +pi to -pi.
REQ-024 SHALL go to IDLE from any state on the edge where enable_i=0; no strobe follows.
REQ-025 SHALL sample div_i and freq_word_i only at the counter compare and tick edges respectively.

Reset
REQ-026 SHALL, on rstn_i=0, asynchronously force state IDLE, counter 0, acc 0, Z_o 0, strb_data_valid_o 0, busy_o 0, overrun_o 0; X_o=X_INIT, Y_o=0.
REQ-027 SHALL, after reset release, act only from the first rising edge with rstn_i=1; reset mid-WAIT discards the pending result.

Configuration
REQ-028 SHALL, with PHASE_SEQUENCER_DITHER_EN defined, add an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5, advanced on each tick, reset to seed) and add its bit 0 to the captured Z_o.
REQ-029 SHALL, without PHASE_SEQUENCER_DITHER_EN, contain no LFSR and give Z_o exactly per REQ-016.

Verification
REQ-030 SHALL cover: reset, then enable_i=1, div_i=15, freq_word_i=16'h1000, offset 0, done 9 clocks after each strobe -> strobes every 16 clocks, Z_o = 0x00, 0x10, 0x20, ...
REQ-031 SHALL cover: freq_word_i=16'h4000, offset 8'h40 -> Z_o = 0x40, 0x80, 0xC0, 0x00, wrapping.
REQ-032 SHALL cover: div_i=3, done 9 clocks after strobe -> overrun_o=1 after the second tick; strobes only after done; acc advanced on dropped ticks.
REQ-033 SHALL cover: enable_i=0 during WAIT -> IDLE next edge, overrun_o=0, acc=0; re-enable restarts with Z_o=offset.
REQ-034 SHALL cover: rstn_i low mid-ISSUE, asynchronous to clock -> strb_data_valid_o=0 immediately, all state per REQ-026.
REQ-035 SHALL cover: with PHASE_SEQUENCER_DITHER_EN, freq_word_i=0, offset 0 -> Z_o sequence equals LFSR bit 0 from seed 8'hA5.
